// File: rtl/chrono_pkg.sv
// rtl/chrono_pkg.sv - shared chronometer widths, display modes and digit slices
package chrono_pkg;

    localparam int DIGIT_W = 4;
    localparam int TIME_W  = 24;

    localparam logic [1:0] MODE_LIVE   = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_RECALL = 2'd2;

    // Digit positions inside a packed time word, counted from the LSB digit
    localparam int DIG_HUNDREDTHS = 0;
    localparam int DIG_TENTHS     = 1;
    localparam int DIG_SEC        = 2;
    localparam int DIG_SEC_TENS   = 3;
    localparam int DIG_MIN        = 4;
    localparam int DIG_MIN_TENS   = 5;

    // State values double as the disp_mode encoding
    typedef enum logic [1:0] {
        ST_LIVE   = MODE_LIVE,
        ST_HOLD   = MODE_HOLD,
        ST_RECALL = MODE_RECALL
    } lap_state_t;

    function automatic logic [DIGIT_W-1:0] get_digit(input logic [TIME_W-1:0] t, input int idx);
        return t[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/lap_memory_if.sv
// rtl/lap_memory_if.sv - live-time input and display output bundle for lap_memory
interface lap_memory_if #(
    parameter int IDX_W = 3
);
    import chrono_pkg::*;

    logic                running;
    logic [TIME_W-1:0]   live_bcd;
    logic                lap_pulse;
    logic                view_pulse;
    logic [TIME_W-1:0]   disp_bcd;
    logic [1:0]          disp_mode;
    logic [IDX_W:0]      lap_count;
    logic [IDX_W-1:0]    view_idx;
    logic                full;

    modport master (
        output running, live_bcd, lap_pulse, view_pulse,
        input  disp_bcd, disp_mode, lap_count, view_idx, full
    );

    modport slave (
        input  running, live_bcd, lap_pulse, view_pulse,
        output disp_bcd, disp_mode, lap_count, view_idx, full
    );

endinterface

// File: rtl/lap_ram.sv
// rtl/lap_ram.sv - lap time store, synchronous write, combinational read, no reset
module lap_ram
    import chrono_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [TIME_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [TIME_W-1:0] o_rdata
);

    logic [TIME_W-1:0] r_mem [DEPTH];

    // Write the captured lap into its slot
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lap_memory.sv
// rtl/lap_memory.sv - lap capture, display hold and recall between counter and decoders
module lap_memory
    import chrono_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int IDX_W       = 3,
    parameter int HOLD_CYCLES = 150000000
) (
    input  logic         CLOCK_50,
    input  logic         rst_db,
    lap_memory_if.slave  bus
);

    localparam int                 CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W:0]     DEPTH_C   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]     ONE_C     = (IDX_W+1)'(1);

    lap_state_t          r_state;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [IDX_W:0]      r_lap_count;
    logic [IDX_W-1:0]    r_view_idx;
    logic [TIME_W-1:0]   r_disp;

    lap_state_t          w_state_nxt;
    logic [CNT_W-1:0]    w_hold_nxt;
    logic [IDX_W-1:0]    w_view_nxt;
    logic [TIME_W-1:0]   w_disp_nxt;
    logic [TIME_W-1:0]   w_rd_data;
    logic                w_full;
    logic                w_accept;
    logic                w_last_view;

    assign w_full      = (r_lap_count == DEPTH_C);
    // A rejected lap_pulse has no effect at all, so it never masks view_pulse
    assign w_accept    = bus.lap_pulse & bus.running & ~w_full;
    assign w_last_view = ({1'b0, r_view_idx} == (r_lap_count - ONE_C));

    lap_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_lap_ram (
        .i_clk   (CLOCK_50),
        .i_we    (w_accept),
        .i_waddr (r_lap_count[IDX_W-1:0]),
        .i_wdata (bus.live_bcd),
        .i_raddr (r_view_idx),
        .o_rdata (w_rd_data)
    );

    // Next state, hold countdown, recall index and display source
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_view_nxt  = r_view_idx;
        w_disp_nxt  = r_disp;
        case (r_state)
            ST_LIVE: begin
                w_disp_nxt = bus.live_bcd;
                if (w_accept) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = HOLD_LOAD;
                end else if (bus.view_pulse && (r_lap_count != '0)) begin
                    w_state_nxt = ST_RECALL;
                    w_view_nxt  = '0;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_disp_nxt = bus.live_bcd;
                    w_hold_nxt = HOLD_LOAD;
                end else if (bus.view_pulse) begin
                    w_state_nxt = ST_RECALL;
                    w_view_nxt  = '0;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_LIVE;
                end else begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                end
            end
            ST_RECALL: begin
                w_disp_nxt = w_rd_data;
                if (!w_accept && bus.view_pulse) begin
                    if (w_last_view) begin
                        w_state_nxt = ST_LIVE;
                        w_view_nxt  = '0;
                    end else begin
                        w_view_nxt = r_view_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_LIVE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLOCK_50 or posedge rst_db) begin
        if (rst_db) begin
            r_state     <= ST_LIVE;
            r_hold_cnt  <= '0;
            r_lap_count <= '0;
            r_view_idx  <= '0;
            r_disp      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_view_idx <= w_view_nxt;
            r_disp     <= w_disp_nxt;
            if (w_accept) begin
                r_lap_count <= r_lap_count + ONE_C;
            end
        end
    end

    assign bus.disp_bcd  = r_disp;
    assign bus.disp_mode = r_state;
    assign bus.lap_count = r_lap_count;
    assign bus.view_idx  = r_view_idx;
    assign bus.full      = w_full;

endmodule

// File: tb/tb_lap_memory.sv
// tb/tb_lap_memory.sv - randomized and directed bench for lap_memory
module tb_lap_memory;
    import chrono_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int HOLD  = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lap_memory_if #(.IDX_W(IDX_W)) bus ();

    lap_memory #(
        .DEPTH       (DEPTH),
        .IDX_W       (IDX_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLOCK_50 (clk),
        .rst_db   (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of stored laps plus what the user currently sees
    logic [23:0] m_laps[$];
    int          m_mode;
    int          m_hold_left;
    int          m_view;
    logic [23:0] m_disp;

    task automatic model_reset();
        m_laps.delete();
        m_mode      = 0;
        m_hold_left = 0;
        m_view      = 0;
        m_disp      = '0;
    endtask

    task automatic model_step();
        logic        acc;
        logic [23:0] shown;
        acc = bus.lap_pulse && bus.running && (m_laps.size() < DEPTH);
        if (m_mode == 0)      shown = bus.live_bcd;
        else if (m_mode == 1) shown = acc ? bus.live_bcd : m_disp;
        else                  shown = m_laps[m_view];
        m_disp = shown;
        if (acc) begin
            m_laps.push_back(bus.live_bcd);
            if (m_mode != 2) begin
                m_mode      = 1;
                m_hold_left = HOLD - 1;
            end
        end else if (bus.view_pulse) begin
            if (m_mode == 0 && m_laps.size() > 0) begin
                m_mode = 2; m_view = 0;
            end else if (m_mode == 1) begin
                m_mode = 2; m_view = 0;
            end else if (m_mode == 2) begin
                if (m_view == m_laps.size() - 1) begin
                    m_mode = 0; m_view = 0;
                end else begin
                    m_view = m_view + 1;
                end
            end
        end else if (m_mode == 1) begin
            if (m_hold_left == 0) m_mode = 0;
            else m_hold_left = m_hold_left - 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        bus.lap_pulse  = 1'b0;
        bus.view_pulse = 1'b0;
    endtask

    task automatic apply_reset();
        bus.lap_pulse  = 1'b0;
        bus.view_pulse = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [23:0] rand_time();
        logic [23:0] t;
        t[23:20] = 4'($urandom_range(5, 0));
        t[19:16] = 4'($urandom_range(9, 0));
        t[15:12] = 4'($urandom_range(5, 0));
        t[11:8]  = 4'($urandom_range(9, 0));
        t[7:4]   = 4'($urandom_range(9, 0));
        t[3:0]   = 4'($urandom_range(9, 0));
        return t;
    endfunction

    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.disp_bcd !== 24'h0 || bus.disp_mode !== 2'd0 || bus.lap_count !== 4'd0 ||
            bus.view_idx !== 3'd0 || bus.full !== 1'b0) begin
            bad++;
            $display("FAIL reset: disp=%h mode=%0d cnt=%0d idx=%0d full=%b required all 0",
                     bus.disp_bcd, bus.disp_mode, bus.lap_count, bus.view_idx, bus.full);
        end
    endtask

    task automatic test_live();
        apply_reset();
        bus.running  = 1'b1;
        bus.live_bcd = 24'h012345;
        cycle();
        total++;
        if (bus.disp_bcd !== 24'h012345 || bus.disp_mode !== MODE_LIVE || bus.lap_count !== 4'd0) begin
            bad++;
            $display("FAIL live: disp=%h mode=%0d cnt=%0d required 012345/0/0",
                     bus.disp_bcd, bus.disp_mode, bus.lap_count);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        bus.running   = 1'b1;
        bus.live_bcd  = 24'h000512;
        bus.lap_pulse = 1'b1;
        cycle();
        bus.live_bcd = 24'h000600;
        for (int i = 0; i < HOLD; i++) begin
            total++;
            if (bus.disp_bcd !== 24'h000512 || bus.disp_mode !== MODE_HOLD || bus.lap_count !== 4'd1) begin
                bad++;
                $display("FAIL hold[%0d]: disp=%h mode=%0d cnt=%0d required 000512/1/1",
                         i, bus.disp_bcd, bus.disp_mode, bus.lap_count);
            end
            cycle();
        end
        total++;
        if (bus.disp_mode !== MODE_LIVE) begin
            bad++;
            $display("FAIL hold_expire: mode=%0d required 0", bus.disp_mode);
        end
        cycle();
        total++;
        if (bus.disp_bcd !== 24'h000600 || bus.disp_mode !== MODE_LIVE) begin
            bad++;
            $display("FAIL hold_resume: disp=%h mode=%0d required 000600/0", bus.disp_bcd, bus.disp_mode);
        end
    endtask

    task automatic test_capture_rules();
        apply_reset();
        bus.running   = 1'b0;
        bus.live_bcd  = 24'h001111;
        bus.lap_pulse = 1'b1;
        cycle();
        total++;
        if (bus.lap_count !== 4'd0 || bus.disp_mode !== MODE_LIVE) begin
            bad++;
            $display("FAIL stopped_lap: cnt=%0d mode=%0d required 0/0", bus.lap_count, bus.disp_mode);
        end
        bus.running = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.live_bcd  = 24'h000100 * (i + 1);
            bus.lap_pulse = 1'b1;
            cycle();
            cycle();
        end
        total++;
        if (bus.full !== 1'b1 || bus.lap_count !== 4'd8) begin
            bad++;
            $display("FAIL fill: full=%b cnt=%0d required 1/8", bus.full, bus.lap_count);
        end
        bus.live_bcd  = 24'h009999;
        bus.lap_pulse = 1'b1;
        cycle();
        total++;
        if (bus.full !== 1'b1 || bus.lap_count !== 4'd8 || bus.disp_bcd !== m_disp) begin
            bad++;
            $display("FAIL ninth_lap: full=%b cnt=%0d disp=%h required 1/8/%h",
                     bus.full, bus.lap_count, bus.disp_bcd, m_disp);
        end
    endtask

    task automatic test_recall();
        logic [23:0] vals [3];
        vals[0] = 24'h000100; vals[1] = 24'h000200; vals[2] = 24'h000300;
        apply_reset();
        bus.view_pulse = 1'b1;
        cycle();
        total++;
        if (bus.disp_mode !== MODE_LIVE) begin
            bad++;
            $display("FAIL empty_view: mode=%0d required 0", bus.disp_mode);
        end
        bus.running = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.live_bcd  = vals[i];
            bus.lap_pulse = 1'b1;
            cycle();
        end
        bus.live_bcd = 24'h004000;
        for (int i = 0; i < HOLD + 2; i++) cycle();
        for (int k = 0; k < 3; k++) begin
            bus.view_pulse = 1'b1;
            cycle();
            cycle();
            total++;
            if (bus.disp_bcd !== vals[k] || bus.view_idx !== 3'(k) || bus.disp_mode !== MODE_RECALL) begin
                bad++;
                $display("FAIL recall[%0d]: disp=%h idx=%0d mode=%0d required %h/%0d/2",
                         k, bus.disp_bcd, bus.view_idx, bus.disp_mode, vals[k], k);
            end
        end
        bus.view_pulse = 1'b1;
        cycle();
        total++;
        if (bus.disp_mode !== MODE_LIVE || bus.view_idx !== 3'd0) begin
            bad++;
            $display("FAIL recall_exit: mode=%0d idx=%0d required 0/0", bus.disp_mode, bus.view_idx);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        bus.running    = 1'b1;
        bus.live_bcd   = 24'h000777;
        bus.lap_pulse  = 1'b1;
        bus.view_pulse = 1'b1;
        cycle();
        total++;
        if (bus.disp_mode !== MODE_HOLD || bus.lap_count !== 4'd1) begin
            bad++;
            $display("FAIL lap_over_view: mode=%0d cnt=%0d required 1/1", bus.disp_mode, bus.lap_count);
        end
        bus.view_pulse = 1'b1;
        cycle();
        cycle();
        bus.live_bcd  = 24'h000888;
        bus.lap_pulse = 1'b1;
        cycle();
        total++;
        if (bus.lap_count !== 4'd2 || bus.disp_mode !== MODE_RECALL || bus.view_idx !== 3'd0 ||
            bus.disp_bcd !== 24'h000777) begin
            bad++;
            $display("FAIL recall_capture: cnt=%0d mode=%0d idx=%0d disp=%h required 2/2/0/000777",
                     bus.lap_count, bus.disp_mode, bus.view_idx, bus.disp_bcd);
        end
    endtask

    task automatic test_async_reset();
        for (int s = 0; s < 2; s++) begin
            apply_reset();
            bus.running   = 1'b1;
            bus.live_bcd  = 24'h000345;
            bus.lap_pulse = 1'b1;
            cycle();
            if (s == 0) begin
                for (int i = 0; i < 4; i++) cycle();
            end else begin
                bus.view_pulse = 1'b1;
                cycle();
                cycle();
            end
            total++;
            if (bus.disp_mode !== 2'(s + 1)) begin
                bad++;
                $display("FAIL pre_reset[%0d]: mode=%0d required %0d", s, bus.disp_mode, s + 1);
            end
            rst = 1'b1;
            #1;
            total++;
            if (bus.disp_bcd !== 24'h0 || bus.disp_mode !== 2'd0 || bus.lap_count !== 4'd0 ||
                bus.view_idx !== 3'd0 || bus.full !== 1'b0) begin
                bad++;
                $display("FAIL async_reset[%0d]: disp=%h mode=%0d cnt=%0d idx=%0d required all 0",
                         s, bus.disp_bcd, bus.disp_mode, bus.lap_count, bus.view_idx);
            end
            #1;
            rst = 1'b0;
            model_reset();
            bus.live_bcd = 24'h000432;
            cycle();
            total++;
            if (bus.disp_mode !== MODE_LIVE || bus.lap_count !== 4'd0 || bus.disp_bcd !== 24'h000432) begin
                bad++;
                $display("FAIL after_reset[%0d]: mode=%0d cnt=%0d disp=%h required 0/0/000432",
                         s, bus.disp_mode, bus.lap_count, bus.disp_bcd);
            end
        end
    endtask

    task automatic test_random();
        int r;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(79, 0) == 0) apply_reset();
            bus.running  = ($urandom_range(7, 0) != 0);
            bus.live_bcd = rand_time();
            r = $urandom_range(15, 0);
            if (r < 2) bus.lap_pulse = 1'b1;
            else if (r < 4) bus.view_pulse = 1'b1;
            else if (r == 4 && bus.running && m_laps.size() < DEPTH) begin
                bus.lap_pulse  = 1'b1;
                bus.view_pulse = 1'b1;
            end
            cycle();
            total++;
            if (bus.disp_bcd !== m_disp || bus.disp_mode !== 2'(m_mode) ||
                bus.lap_count !== 4'(m_laps.size()) || bus.view_idx !== 3'(m_view) ||
                bus.full !== (m_laps.size() == DEPTH)) begin
                bad++;
                $display("FAIL random[%0d]: disp=%h mode=%0d cnt=%0d idx=%0d full=%b required %h/%0d/%0d/%0d/%b",
                         n, bus.disp_bcd, bus.disp_mode, bus.lap_count, bus.view_idx, bus.full,
                         m_disp, m_mode, m_laps.size(), m_view, (m_laps.size() == DEPTH));
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.running    = 1'b0;
        bus.live_bcd   = '0;
        bus.lap_pulse  = 1'b0;
        bus.view_pulse = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_live();
        test_hold();
        test_capture_rules();
        test_recall();
        test_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
